bcd_countdown_timer_p: RTL and testbench
========================================

// Module: bcd_countdown_timer_p
// PURPOSE
//   Parametrised mm:ss timer with BCD display outputs. Counts down to 00:00, or up to a preset.
//   Runs fully synchronously on one clock: internal 1 Hz prescaler, no derived/ripple clocks.
//   Adds pause/resume, optional auto-reload and a DONE blink indicator.
//   Sits between the board buttons and the 7-segment display/LED driver.
// PARAMETERS
//   TICK_DIV     50_000_000  Clk cycles per counted second (>=2)
//   BLINK_DIV    25_000_000  Clk cycles per blink_led toggle in DONE (>=1)
//   MAX_MIN      59          largest settable minute value (1..99)
//   AUTO_RELOAD  0           1: on expiry reload preset and keep running; 0: stop in DONE
// PORTS
//   Clk        in   1  system clock, all logic on rising edge
//   reset_n    in   1  asynchronous, active-low reset
//   set_inc_n  in   1  active-low button, preset +1 on falling edge (IDLE only)
//   set_dec_n  in   1  active-low button, preset -1 on falling edge (IDLE only)
//   set_field  in   1  0: buttons adjust minutes; 1: buttons adjust seconds
//   mode_up    in   1  0: count down preset->00:00; 1: count up 00:00->preset (sampled in IDLE)
//   start      in   1  level; starts from IDLE, restarts from DONE
//   pause      in   1  level; holds count while high
//   clear      in   1  synchronous abort to IDLE; preset kept
//   init_min   out  8  preset minutes, BCD {tens,units}
//   init_sec   out  8  preset seconds, BCD
//   count_min  out  8  live minutes, BCD
//   count_sec  out  8  live seconds, BCD
//   state      out  2  IDLE=0 RUN=1 PAUSED=2 DONE=3
//   done       out  1  level in DONE; 1-cycle pulse per expiry when AUTO_RELOAD=1
//   blink_led  out  1  toggles every BLINK_DIV cycles in DONE, else 0
// BEHAVIOUR
//   Reset (reset_n low): all outputs 0, state IDLE, prescaler 0, button edge regs 1.
//   IDLE:
//   - Falling edge of a set button (registered previous value) adjusts the field chosen by set_field.
//   - inc wraps MAX_MIN->0 (min), 59->0 (sec); dec wraps 0->MAX_MIN / 0->59.
//   - Both buttons falling in same cycle: ignored.
//   - count = preset (down mode) or 00:00 (up mode), following preset changes in the same cycle.
//   - start=1 and preset!=00:00 -> RUN next cycle, prescaler cleared. start with preset 00:00 -> stay IDLE.
//   RUN:
//   - Prescaler counts 0..TICK_DIV-1; wrap cycle is the sec tick.
//   - Down: sec 00->59 with minute borrow. Up: sec 59->00 with minute carry.
//   - Expiry: the tick that makes count==00:00 (down) or count==preset (up).
//     AUTO_RELOAD=0 -> DONE next cycle. AUTO_RELOAD=1 -> count reloads (preset / 00:00), done pulses 1 cycle, stay RUN.
//   - pause=1 -> PAUSED; prescaler frozen, not cleared. Tick coincident with pause is discarded.
//   PAUSED: pause=0 -> RUN, prescaler resumes from held value. Buttons ignored in RUN/PAUSED/DONE.
//   DONE: count frozen at final value; blink counter runs, blink_led starts 0 and toggles every BLINK_DIV cycles.
//     start=1 -> reload count, blink_led 0, RUN.
//   clear=1 (any state): IDLE next cycle, count reloaded, blink_led/done 0, prescaler 0. clear beats start/pause.
//   Priority: reset_n > clear > pause > start > tick.
//   Arithmetic: BCD digits never leave 0..9; tens digit of seconds never exceeds 5.
// STRUCTURE
//   Package timer_pkg: state encodings (TIMER_IDLE/RUN/PAUSED/DONE), BCD_ZERO, BCD_59 constants.
//   Sub-module bcd_mod_counter (param MOD): 2-digit BCD counter with load, inc/dec enables, wrap flag.
//     Instantiated for seconds (MOD=60) and minutes (MOD=MAX_MIN+1); clocked by Clk, enabled by tick/borrow.
//   Top holds FSM, prescaler, blink counter, button edge detection, preset registers.
// TESTING (TICK_DIV=4, BLINK_DIV=2, MAX_MIN=59)
//   Set 01:00 via 1 inc falling edge (set_field=0), start -> count_sec 59 after 4 cycles; 00:00 at 60th tick; then DONE, done=1.
//   DONE: blink_led 0,0,1,1,0,0 per cycle; start -> count 01:00, RUN, blink_led 0.
//   Preset 00:00 + start -> state stays IDLE. Dec at 00 min -> init_min=8'h59.
//   Pause after 2 prescaler cycles for 10 cycles -> count unchanged; first tick 2 cycles after release.
//   mode_up=1, preset 00:03 -> counts 00:01,00:02,00:03 then DONE. AUTO_RELOAD=1 -> done pulses, count 00:00, stays RUN.
//   reset_n low mid-RUN (async, between edges) -> all outputs 0 immediately. clear mid-RUN -> IDLE, count=preset.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared state encodings, BCD constants and BCD step helpers for the mm:ss timer.
package timer_pkg;

    typedef enum logic [1:0] {
        TIMER_IDLE   = 2'd0,
        TIMER_RUN    = 2'd1,
        TIMER_PAUSED = 2'd2,
        TIMER_DONE   = 2'd3
    } timer_state_t;

    localparam logic [7:0] BCD_ZERO = 8'h00;
    localparam logic [7:0] BCD_59   = 8'h59;

    function automatic logic [7:0] to_bcd(input int unsigned n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    // Step a two-digit BCD value, wrapping between 00 and max_v.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        if (v == max_v)       return BCD_ZERO;
        if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max_v);
        if (v == BCD_ZERO)    return max_v;
        if (v[3:0] == 4'd0)   return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo-MOD counter with load priority over inc/dec; wrap flags the step that rolls over.
module bcd_mod_counter
    import timer_pkg::*;
#(
    parameter int MOD = 60
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] count,
    output logic       wrap
);

    localparam logic [7:0] MAX_V = to_bcd(MOD - 1);

    logic [7:0] count_reg;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= BCD_ZERO;
        end else if (load) begin
            count_reg <= load_val;
        end else if (inc) begin
            count_reg <= bcd_inc(count_reg, MAX_V);
        end else if (dec) begin
            count_reg <= bcd_dec(count_reg, MAX_V);
        end
    end

    assign count = count_reg;
    assign wrap  = (inc && (count_reg == MAX_V)) || (dec && (count_reg == BCD_ZERO));

endmodule

// File: rtl/bcd_countdown_timer_p.sv
// mm:ss BCD timer: preset buttons, up/down counting from an internal 1 Hz prescaler,
// pause/resume, optional auto-reload and a blinking DONE indicator.
module bcd_countdown_timer_p
    import timer_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int BLINK_DIV   = 25_000_000,
    parameter int MAX_MIN     = 59,
    parameter int AUTO_RELOAD = 0
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic       set_inc_n,
    input  logic       set_dec_n,
    input  logic       set_field,
    input  logic       mode_up,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [7:0] init_min,
    output logic [7:0] init_sec,
    output logic [7:0] count_min,
    output logic [7:0] count_sec,
    output logic [1:0] state,
    output logic       done,
    output logic       blink_led
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [PW-1:0] PRESC_MAX   = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX   = BW'(BLINK_DIV - 1);
    localparam logic [7:0]    MAX_MIN_BCD = to_bcd(MAX_MIN);
    localparam bit            RELOAD      = (AUTO_RELOAD != 0);

    timer_state_t   state_reg, state_next;
    logic [7:0]     preset_min_reg, preset_min_next;
    logic [7:0]     preset_sec_reg, preset_sec_next;
    logic           inc_prev_reg, dec_prev_reg;
    logic           mode_reg, mode_next;
    logic [PW-1:0]  presc_reg, presc_next;
    logic [BW-1:0]  blink_cnt_reg, blink_cnt_next;
    logic           blink_led_reg, blink_led_next;
    logic           done_reg, done_next;

    logic           adj_inc, adj_dec, tick, expiry, reload_up;
    logic           cnt_load, sec_inc, sec_dec, sec_wrap, min_wrap;
    logic [7:0]     sec_q, min_q, up_next_sec, up_next_min;
    logic [7:0]     reload_min, reload_sec;

    always_comb begin
        state_next      = state_reg;
        preset_min_next = preset_min_reg;
        preset_sec_next = preset_sec_reg;
        presc_next      = '0;
        blink_cnt_next  = '0;
        blink_led_next  = 1'b0;

        // Simultaneous presses on both buttons cancel out.
        adj_inc = (state_reg == TIMER_IDLE) && inc_prev_reg && !set_inc_n && !(dec_prev_reg && !set_dec_n);
        adj_dec = (state_reg == TIMER_IDLE) && dec_prev_reg && !set_dec_n && !(inc_prev_reg && !set_inc_n);
        if (adj_inc) begin
            if (set_field) preset_sec_next = bcd_inc(preset_sec_reg, BCD_59);
            else           preset_min_next = bcd_inc(preset_min_reg, MAX_MIN_BCD);
        end else if (adj_dec) begin
            if (set_field) preset_sec_next = bcd_dec(preset_sec_reg, BCD_59);
            else           preset_min_next = bcd_dec(preset_min_reg, MAX_MIN_BCD);
        end

        tick        = (state_reg == TIMER_RUN) && !clear && !pause && (presc_reg == PRESC_MAX);
        up_next_sec = bcd_inc(sec_q, BCD_59);
        up_next_min = (sec_q == BCD_59) ? bcd_inc(min_q, MAX_MIN_BCD) : min_q;
        // A minute rollover can only mean the target was passed, so it is treated as expiry too.
        expiry = tick && (mode_reg ? ({up_next_min, up_next_sec} == {preset_min_reg, preset_sec_reg})
                                   : ((min_q == BCD_ZERO) && (sec_q == 8'h01))) || min_wrap;

        if (clear) begin
            state_next = TIMER_IDLE;
        end else begin
            unique case (state_reg)
                TIMER_IDLE:   if (start && ({preset_min_reg, preset_sec_reg} != 16'h0000)) state_next = TIMER_RUN;
                TIMER_RUN:    if (pause) state_next = TIMER_PAUSED;
                              else if (expiry && !RELOAD) state_next = TIMER_DONE;
                TIMER_PAUSED: if (!pause) state_next = TIMER_RUN;
                TIMER_DONE:   if (start) state_next = TIMER_RUN;
                default:      state_next = TIMER_IDLE;
            endcase
        end

        if (!clear && (state_reg == TIMER_RUN) && !pause) begin
            presc_next = (presc_reg == PRESC_MAX) ? '0 : presc_reg + PW'(1);
        end else if (!clear && (state_reg == TIMER_RUN || state_reg == TIMER_PAUSED)) begin
            presc_next = presc_reg;
        end

        if ((state_reg == TIMER_DONE) && (state_next == TIMER_DONE)) begin
            blink_cnt_next = (blink_cnt_reg == BLINK_MAX) ? '0 : blink_cnt_reg + BW'(1);
            blink_led_next = (blink_cnt_reg == BLINK_MAX) ? !blink_led_reg : blink_led_reg;
        end

        done_next = !clear && ((state_next == TIMER_DONE) || (expiry && RELOAD));
        mode_next = (state_reg == TIMER_IDLE) ? mode_up : mode_reg;

        reload_up  = (state_reg == TIMER_IDLE) ? mode_up : mode_reg;
        reload_min = reload_up ? BCD_ZERO : preset_min_next;
        reload_sec = reload_up ? BCD_ZERO : preset_sec_next;
        cnt_load   = clear || (state_reg == TIMER_IDLE) || ((state_reg == TIMER_DONE) && start)
                   || (expiry && RELOAD);
        sec_inc    = tick && mode_reg;
        sec_dec    = tick && !mode_reg;
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= TIMER_IDLE;
            preset_min_reg <= BCD_ZERO;
            preset_sec_reg <= BCD_ZERO;
            inc_prev_reg   <= 1'b1;
            dec_prev_reg   <= 1'b1;
            mode_reg       <= 1'b0;
            presc_reg      <= '0;
            blink_cnt_reg  <= '0;
            blink_led_reg  <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            preset_min_reg <= preset_min_next;
            preset_sec_reg <= preset_sec_next;
            inc_prev_reg   <= set_inc_n;
            dec_prev_reg   <= set_dec_n;
            mode_reg       <= mode_next;
            presc_reg      <= presc_next;
            blink_cnt_reg  <= blink_cnt_next;
            blink_led_reg  <= blink_led_next;
            done_reg       <= done_next;
        end
    end

    bcd_mod_counter #(.MOD(60)) u_sec (
        .Clk(Clk), .reset_n(reset_n), .load(cnt_load), .load_val(reload_sec),
        .inc(sec_inc), .dec(sec_dec), .count(sec_q), .wrap(sec_wrap)
    );

    bcd_mod_counter #(.MOD(MAX_MIN + 1)) u_min (
        .Clk(Clk), .reset_n(reset_n), .load(cnt_load), .load_val(reload_min),
        .inc(sec_inc && sec_wrap), .dec(sec_dec && sec_wrap), .count(min_q), .wrap(min_wrap)
    );

    assign init_min  = preset_min_reg;
    assign init_sec  = preset_sec_reg;
    assign count_min = min_q;
    assign count_sec = sec_q;
    assign state     = state_reg;
    assign done      = done_reg;
    assign blink_led = blink_led_reg;

endmodule

// File: tb/tb_bcd_countdown_timer_p.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge monitor compares them
// against a stop-in-DONE instance (dut 0) and an auto-reload instance (dut 1).
module tb_bcd_countdown_timer_p;

    logic Clk, reset_n;
    logic set_inc_n, set_dec_n, set_field, mode_up, start, pause, clear;
    logic [7:0] im_o [2];
    logic [7:0] is_o [2];
    logic [7:0] cm_o [2];
    logic [7:0] cs_o [2];
    logic [1:0] st_o [2];
    logic       dn_o [2];
    logic       bl_o [2];

    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSED = 2'd2, S_DONE = 2'd3;

    bcd_countdown_timer_p #(.TICK_DIV(4), .BLINK_DIV(2), .MAX_MIN(59), .AUTO_RELOAD(0)) dut0 (
        .Clk(Clk), .reset_n(reset_n), .set_inc_n(set_inc_n), .set_dec_n(set_dec_n),
        .set_field(set_field), .mode_up(mode_up), .start(start), .pause(pause), .clear(clear),
        .init_min(im_o[0]), .init_sec(is_o[0]), .count_min(cm_o[0]), .count_sec(cs_o[0]),
        .state(st_o[0]), .done(dn_o[0]), .blink_led(bl_o[0])
    );

    bcd_countdown_timer_p #(.TICK_DIV(4), .BLINK_DIV(2), .MAX_MIN(59), .AUTO_RELOAD(1)) dut1 (
        .Clk(Clk), .reset_n(reset_n), .set_inc_n(set_inc_n), .set_dec_n(set_dec_n),
        .set_field(set_field), .mode_up(mode_up), .start(start), .pause(pause), .clear(clear),
        .init_min(im_o[1]), .init_sec(is_o[1]), .count_min(cm_o[1]), .count_sec(cs_o[1]),
        .state(st_o[1]), .done(dn_o[1]), .blink_led(bl_o[1])
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         d;
        logic [1:0] st;
        logic [7:0] cm, cs, im, is;
        logic       dn, bl;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_assert = 0;
    int    n_fail   = 0;

    task automatic do_check(input string nm, input int d, input logic [1:0] st,
                            input logic [7:0] cm, input logic [7:0] cs,
                            input logic [7:0] im, input logic [7:0] is,
                            input logic dn, input logic bl);
        n_assert++;
        if (st_o[d] !== st || cm_o[d] !== cm || cs_o[d] !== cs || im_o[d] !== im ||
            is_o[d] !== is || dn_o[d] !== dn || bl_o[d] !== bl) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc %0d: got st=%0d cnt=%h:%h init=%h:%h done=%b blink=%b, required st=%0d cnt=%h:%h init=%h:%h done=%b blink=%b",
                     nm, d, cyc, st_o[d], cm_o[d], cs_o[d], im_o[d], is_o[d], dn_o[d], bl_o[d],
                     st, cm, cs, im, is, dn, bl);
        end else begin
            $display("ok   %s dut%0d cyc %0d: st=%0d cnt=%h:%h init=%h:%h done=%b blink=%b",
                     nm, d, cyc, st, cm, cs, im, is, dn, bl);
        end
    endtask

    // Expected snapshot k rising edges from now, inserted in cycle order.
    task automatic push(input int k, input int d, input string nm, input logic [1:0] st,
                        input logic [7:0] cm, input logic [7:0] cs,
                        input logic [7:0] im, input logic [7:0] is,
                        input logic dn, input logic bl);
        exp_t e;
        int   idx;
        e.cyc = cyc + k; e.d = d; e.st = st; e.cm = cm; e.cs = cs;
        e.im = im; e.is = is; e.dn = dn; e.bl = bl;
        idx = exp_q.size();
        while (idx > 0 && exp_q[idx-1].cyc > e.cyc) idx--;
        exp_q.insert(idx, e);
        name_q.insert(idx, nm);
    endtask

    task automatic push2(input int k, input string nm, input logic [1:0] st,
                         input logic [7:0] cm, input logic [7:0] cs,
                         input logic [7:0] im, input logic [7:0] is);
        push(k, 0, nm, st, cm, cs, im, is, 1'b0, 1'b0);
        push(k, 1, nm, st, cm, cs, im, is, 1'b0, 1'b0);
    endtask

    always @(negedge Clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            if (exp_q[0].cyc < cyc) begin
                n_assert++;
                n_fail++;
                $display("FAIL %s: sample for cycle %0d missed, monitor at %0d", name_q[0], exp_q[0].cyc, cyc);
            end else begin
                do_check(name_q[0], exp_q[0].d, exp_q[0].st, exp_q[0].cm, exp_q[0].cs,
                         exp_q[0].im, exp_q[0].is, exp_q[0].dn, exp_q[0].bl);
            end
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
        end
    end

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge Clk);
    endtask

    initial begin
        int base;
        int guard;
        set_inc_n = 1'b1; set_dec_n = 1'b1; set_field = 1'b0; mode_up = 1'b0;
        start = 1'b0; pause = 1'b0; clear = 1'b0; reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        push2(1, "reset", S_IDLE, 8'h00, 8'h00, 8'h00, 8'h00);

        // Preset 01:00 with one minute press, then count it down.
        step(); set_inc_n = 1'b0;
        push2(1, "set_inc_min", S_IDLE, 8'h01, 8'h00, 8'h01, 8'h00);
        step(); set_inc_n = 1'b1;
        step(); start = 1'b1; base = cyc;
        push2(1,   "start",      S_RUN, 8'h01, 8'h00, 8'h01, 8'h00);
        push2(4,   "pre_tick",   S_RUN, 8'h01, 8'h00, 8'h01, 8'h00);
        push2(5,   "first_tick", S_RUN, 8'h00, 8'h59, 8'h01, 8'h00);
        push2(237, "tick59",     S_RUN, 8'h00, 8'h01, 8'h01, 8'h00);
        push(241, 0, "expiry_done",  S_DONE, 8'h00, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0);
        push(241, 1, "reload_pulse", S_RUN,  8'h01, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0);
        push(242, 1, "reload_after", S_RUN,  8'h01, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0);
        push(242, 0, "blink1", S_DONE, 8'h00, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0);
        push(243, 0, "blink2", S_DONE, 8'h00, 8'h00, 8'h01, 8'h00, 1'b1, 1'b1);
        push(244, 0, "blink3", S_DONE, 8'h00, 8'h00, 8'h01, 8'h00, 1'b1, 1'b1);
        push(245, 0, "blink4", S_DONE, 8'h00, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0);
        push(246, 0, "blink5", S_DONE, 8'h00, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0);
        step(); start = 1'b0;
        wait_cyc(base + 246); start = 1'b1;
        push(1, 0, "restart", S_RUN, 8'h01, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0);
        step(); start = 1'b0; clear = 1'b1;
        push2(1, "clear_run", S_IDLE, 8'h01, 8'h00, 8'h01, 8'h00);

        // Preset edge cases in IDLE.
        step(); clear = 1'b0; set_dec_n = 1'b0;
        push2(1, "dec_min", S_IDLE, 8'h00, 8'h00, 8'h00, 8'h00);
        step(); set_dec_n = 1'b1; start = 1'b1;
        push2(1, "start_zero", S_IDLE, 8'h00, 8'h00, 8'h00, 8'h00);
        step(); start = 1'b0; set_dec_n = 1'b0;
        push2(1, "dec_wrap_min", S_IDLE, 8'h59, 8'h00, 8'h59, 8'h00);
        step(); set_dec_n = 1'b1; set_field = 1'b1;
        step(); set_dec_n = 1'b0;
        push2(1, "dec_wrap_sec", S_IDLE, 8'h59, 8'h59, 8'h59, 8'h59);
        step(); set_dec_n = 1'b1;
        step(); set_inc_n = 1'b0; set_dec_n = 1'b0;
        push2(1, "both_ignored", S_IDLE, 8'h59, 8'h59, 8'h59, 8'h59);
        step(); set_inc_n = 1'b1; set_dec_n = 1'b1;
        step(); set_inc_n = 1'b0;
        push2(1, "inc_wrap_sec", S_IDLE, 8'h59, 8'h00, 8'h59, 8'h00);
        step(); set_inc_n = 1'b1; set_field = 1'b0;
        step(); set_inc_n = 1'b0;
        push2(1, "inc_wrap_min", S_IDLE, 8'h00, 8'h00, 8'h00, 8'h00);
        step(); set_inc_n = 1'b1; set_field = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] v;
            v = 8'(i + 1);
            step(); set_inc_n = 1'b0;
            push2(1, "inc_sec", S_IDLE, 8'h00, v, 8'h00, v);
            step(); set_inc_n = 1'b1;
        end

        // Pause for 10 cycles with the prescaler part-way through a second.
        step(); start = 1'b1; base = cyc;
        push2(1, "pause_start", S_RUN, 8'h00, 8'h03, 8'h00, 8'h03);
        step(); start = 1'b0;
        step();
        step(); pause = 1'b1;
        push2(1,  "paused",        S_PAUSED, 8'h00, 8'h03, 8'h00, 8'h03);
        push2(2,  "paused_notick", S_PAUSED, 8'h00, 8'h03, 8'h00, 8'h03);
        push2(10, "paused_end",    S_PAUSED, 8'h00, 8'h03, 8'h00, 8'h03);
        wait_cyc(base + 13); pause = 1'b0;
        push2(1, "resume",         S_RUN, 8'h00, 8'h03, 8'h00, 8'h03);
        push2(2, "resume_hold",    S_RUN, 8'h00, 8'h03, 8'h00, 8'h03);
        push2(3, "resume_tick",    S_RUN, 8'h00, 8'h02, 8'h00, 8'h03);
        wait_cyc(base + 16); clear = 1'b1;
        push2(1, "clear_mid_run", S_IDLE, 8'h00, 8'h03, 8'h00, 8'h03);

        // Count up 00:00 -> 00:03.
        step(); clear = 1'b0; mode_up = 1'b1;
        push2(1, "up_idle", S_IDLE, 8'h00, 8'h00, 8'h00, 8'h03);
        step(); start = 1'b1; base = cyc;
        push2(1, "up_start", S_RUN, 8'h00, 8'h00, 8'h00, 8'h03);
        push2(5, "up_01",    S_RUN, 8'h00, 8'h01, 8'h00, 8'h03);
        push2(9, "up_02",    S_RUN, 8'h00, 8'h02, 8'h00, 8'h03);
        push(13, 0, "up_done",      S_DONE, 8'h00, 8'h03, 8'h00, 8'h03, 1'b1, 1'b0);
        push(13, 1, "up_reload",    S_RUN,  8'h00, 8'h00, 8'h00, 8'h03, 1'b1, 1'b0);
        push(14, 0, "up_done_hold", S_DONE, 8'h00, 8'h03, 8'h00, 8'h03, 1'b1, 1'b0);
        push(14, 1, "up_pulse_end", S_RUN,  8'h00, 8'h00, 8'h00, 8'h03, 1'b0, 1'b0);
        push(17, 1, "up_rerun",     S_RUN,  8'h00, 8'h01, 8'h00, 8'h03, 1'b0, 1'b0);
        step(); start = 1'b0;

        // Asynchronous reset between clock edges.
        wait_cyc(base + 20);
        #1 reset_n = 1'b0;
        #1;
        do_check("async_reset", 0, S_IDLE, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        do_check("async_reset", 1, S_IDLE, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        step(); reset_n = 1'b1;
        push2(1, "post_reset", S_IDLE, 8'h00, 8'h00, 8'h00, 8'h00);

        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            step();
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL drain: %0d expectations still pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
